// File: rtl/clk_tick_monitor.sv
// Synchronises a divided clock into the fast domain and emits edge strobes.
// Also measures the rise-to-rise period and reports lock, range and timeout status.
module clk_tick_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = 4,
    parameter int TOL         = 0,
    parameter int LOCK_CNT    = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_in,
    input  logic             clr_err,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_range,
    output logic             err_timeout
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int LO_INT = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
    localparam int HI_INT = EXP_PERIOD + TOL;
    localparam logic [CNT_W:0]   LO_BOUND    = (CNT_W+1)'(LO_INT);
    localparam logic [CNT_W:0]   HI_BOUND    = (CNT_W+1)'(HI_INT);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                 prev_q;
    logic                 sync_lvl;
    logic                 rise_det, fall_det;
    logic                 take_period, timeout_evt;
    logic [CNT_W-1:0]     cnt_q;
    logic [RUN_W-1:0]     run_q, run_next;
    logic                 in_range;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // prime_q holds off edge detection until prev_q carries a real post-reset
    // sample, so a level held across reset release never produces a strobe.
    assign rise_det = prime_q[SYNC_STAGES] &  sync_lvl & ~prev_q;
    assign fall_det = prime_q[SYNC_STAGES] & ~sync_lvl &  prev_q;

    assign in_range = ({1'b0, period} >= LO_BOUND) && ({1'b0, period} <= HI_BOUND);
    assign run_next = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_in};
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            prev_q  <= sync_lvl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A rise arriving on the saturation cycle wins over timeout.
    always_comb begin
        state_d     = state_q;
        take_period = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_det) state_d = MEASURE;
            end
            MEASURE, TRACK: begin
                if (rise_det) begin
                    state_d     = TRACK;
                    take_period = 1'b1;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    state_d     = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            cnt_q        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            rise_pulse   <= rise_det;
            fall_pulse   <= fall_det;
            period_valid <= take_period;
            if (take_period) period <= cnt_q;
            if (rise_det)                 cnt_q <= CNT_W'(1);
            else if (cnt_q != TIMEOUT_VAL) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Status follows period_valid by one cycle; error events beat clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            locked      <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (timeout_evt) begin
                run_q  <= '0;
                locked <= 1'b0;
            end else if (period_valid) begin
                if (in_range) begin
                    run_q  <= run_next;
                    locked <= (run_next == RUN_MAX);
                end else begin
                    run_q  <= '0;
                    locked <= 1'b0;
                end
            end
            err_range   <= (err_range & ~clr_err) | (period_valid & ~in_range);
            err_timeout <= (err_timeout & ~clr_err) | timeout_evt;
        end
    end

endmodule
